// File: rtl/sha_mem_responder.sv
// sha_mem_responder: shared-memory bridge between a host loader/reader and a SHA engine.
// Optional SHA_MEM_WPROT_EN makes the 20-word message region read-only to the engine.
module sha_mem_responder #(
  parameter int unsigned DEPTH    = 64,
  parameter int unsigned MSG_BASE = 0,
  parameter int unsigned OUT_BASE = 32,
  parameter int unsigned TIMEOUT  = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_we,
  input  logic [15:0] mem_addr,
  input  logic [31:0] mem_write_data,
  output logic [31:0] mem_read_data,
  output logic        start,
  input  logic        done,
  output logic [15:0] message_addr,
  output logic [15:0] output_addr,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [31:0] ld_data,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic        res_last,
  output logic        err_addr,
  output logic        err_timeout
);
  localparam int AW = $clog2(DEPTH);
  localparam int WW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {LOAD, START, BUSY, DUMP} state_t;
  state_t state, state_n;
  logic [31:0] mem [DEPTH];
  logic [4:0] ld_cnt;
  logic [2:0] dump_idx;
  logic [WW-1:0] wd;
  logic done_q, ld_fire, done_rise, wd_hit, addr_ok, prot, eng_we, eng_bad, we;
  logic [AW-1:0] waddr;
  logic [31:0] wdata;
  assign message_addr = 16'(MSG_BASE);
  assign output_addr = 16'(OUT_BASE);
  assign addr_ok = 32'(mem_addr) < DEPTH;
`ifdef SHA_MEM_WPROT_EN
  assign prot = (32'(mem_addr) - MSG_BASE) < 32'd20;
`else
  assign prot = 1'b0;
`endif
  assign ld_fire = state == LOAD && ld_valid && ld_ready;
  // done_q carries the level seen last cycle, so a done left high by a prior run is not an edge
  assign done_rise = state == BUSY && done && !done_q;
  assign wd_hit = state == BUSY && wd == WW'(TIMEOUT - 1);
  assign eng_we = state == BUSY && mem_we;
  assign eng_bad = eng_we && (!addr_ok || prot);
  assign we = ld_fire || (eng_we && !eng_bad);
  assign waddr = ld_fire ? AW'(MSG_BASE + 32'(ld_cnt)) : mem_addr[AW-1:0];
  assign wdata = ld_fire ? ld_data : mem_write_data;
  assign start = state == START;
  assign res_valid = state == DUMP;
  assign res_last = res_valid && dump_idx == 3'd7;
  assign res_data = res_valid ? mem[AW'(OUT_BASE + 32'(dump_idx))] : '0;
  always_comb begin
    state_n = state;
    case (state)
      LOAD:    state_n = ld_fire && ld_cnt == 5'd19 ? START : LOAD;
      START:   state_n = BUSY;
      BUSY:    state_n = done_rise ? DUMP : wd_hit ? LOAD : BUSY;
      DUMP:    state_n = res_ready && dump_idx == 3'd7 ? LOAD : DUMP;
      default: state_n = LOAD;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= LOAD;
      ld_ready <= 1'b0;
      ld_cnt <= '0;
      dump_idx <= '0;
      wd <= '0;
      done_q <= 1'b0;
      err_addr <= 1'b0;
      err_timeout <= 1'b0;
      mem_read_data <= '0;
    end else begin
      state <= state_n;
      ld_ready <= state_n == LOAD;
      ld_cnt <= state_n == LOAD ? ld_cnt + 5'(ld_fire) : '0;
      dump_idx <= state == DUMP ? dump_idx + 3'(res_ready) : '0;
      wd <= state == BUSY ? wd + 1'b1 : '0;
      done_q <= done;
      err_addr <= start ? 1'b0 : err_addr | eng_bad;
      err_timeout <= start ? 1'b0 : err_timeout | (wd_hit && !done_rise);
      mem_read_data <= addr_ok ? mem[mem_addr[AW-1:0]] : '0;
    end
  end
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
endmodule

// File: tb/tb_sha_mem_responder.sv
// tb_sha_mem_responder: randomized bench with an engine model and a word-level memory reference.
module tb_sha_mem_responder;
  localparam int DEPTH = 64, MSG_BASE = 0, OUT_BASE = 32, TIMEOUT = 1024;
`ifdef SHA_MEM_WPROT_EN
  localparam bit PROT = 1'b1;
`else
  localparam bit PROT = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1, mem_we = 1'b0, done = 1'b0, ld_valid = 1'b0, res_ready = 1'b0;
  logic [15:0] mem_addr = '0;
  logic [31:0] mem_write_data = '0, ld_data = '0;
  logic [31:0] mem_read_data, res_data;
  logic [15:0] message_addr, output_addr;
  logic start, ld_ready, res_valid, res_last, err_addr, err_timeout;
  logic [31:0] ref_mem [DEPTH];
  bit ref_ok [DEPTH];
  logic [31:0] w [20];
  bit exp_err;
  int n_tests, n_fail, start_cnt;

  sha_mem_responder #(.DEPTH(DEPTH), .MSG_BASE(MSG_BASE), .OUT_BASE(OUT_BASE), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .mem_we(mem_we), .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data), .start(start), .done(done), .message_addr(message_addr),
    .output_addr(output_addr), .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_last(res_last),
    .err_addr(err_addr), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (start) start_cnt++;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic rd_chk(input int a);
    mem_addr = 16'(a);
    tick;
    chk("read", mem_read_data, (a < DEPTH) ? ref_mem[a] : 32'd0);
  endtask

  // Loads w[] with random idle beats, leaves the FSM one cycle into BUSY.
  task automatic load_msg;
    start_cnt = 0;
    for (int n = 0; n < 20; n++) begin
      while ($urandom_range(3) == 0) begin
        ld_valid = 1'b0;
        tick;
      end
      chk("ld_ready_load", ld_ready, 1);
      ld_valid = 1'b1;
      ld_data = w[n];
      ref_mem[MSG_BASE + n] = w[n];
      ref_ok[MSG_BASE + n] = 1'b1;
      tick;
    end
    ld_valid = 1'b0;
    chk("ld_ready_off", ld_ready, 0);
    chk("start_pulse", start, 1);
    rd_chk(MSG_BASE + 5);
    chk("start_low", start, 0);
    chk("err_addr_clr", err_addr, 0);
    chk("err_timeout_clr", err_timeout, 0);
    exp_err = 1'b0;
  endtask

  task automatic eng_write(input int a, input logic [31:0] d);
    logic [31:0] old;
    bit known, drop;
    known = a >= DEPTH || ref_ok[a];
    old = (a < DEPTH) ? ref_mem[a] : 32'd0;
    drop = a >= DEPTH || (PROT && a >= MSG_BASE && a < MSG_BASE + 20);
    mem_we = 1'b1;
    mem_addr = 16'(a);
    mem_write_data = d;
    tick;
    mem_we = 1'b0;
    if (known) chk("read_before_write", mem_read_data, old);
    if (drop) exp_err = 1'b1;
    else begin
      ref_mem[a] = d;
      ref_ok[a] = 1'b1;
    end
    chk("err_addr", err_addr, exp_err);
  endtask

  task automatic digest;
    for (int k = 0; k < 16; k++) eng_write(OUT_BASE + k, $urandom);
  endtask

  task automatic fire_done;
    chk("busy_hold", res_valid, 0);
    done = 1'b1;
    tick;
    chk("dump_entry", res_valid, 1);
    done = 1'b0;
  endtask

  task automatic dump(input int n, input int stall_at);
    for (int i = 0; i < n; i++) begin
      int st;
      st = (i == stall_at) ? 5 : int'($urandom_range(2));
      res_ready = 1'b0;
      repeat (st) begin
        chk("stall_valid", res_valid, 1);
        chk("stall_data", res_data, ref_mem[OUT_BASE + i]);
        chk("stall_last", res_last, 32'(i == 7));
        tick;
      end
      res_ready = 1'b1;
      chk("dump_valid", res_valid, 1);
      chk("dump_data", res_data, ref_mem[OUT_BASE + i]);
      chk("dump_last", res_last, 32'(i == 7));
      tick;
    end
    res_ready = 1'b0;
    if (n == 8) begin
      chk("dump_end_valid", res_valid, 0);
      chk("dump_end_ld_ready", ld_ready, 1);
      chk("err_addr_sticky", err_addr, exp_err);
      chk("start_once", start_cnt, 1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    tick;
    tick;
    chk("rst_start", start, 0);
    chk("rst_ld_ready", ld_ready, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_last", res_last, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_mem_read_data", mem_read_data, 0);
    chk("rst_err_addr", err_addr, 0);
    chk("rst_err_timeout", err_timeout, 0);
    chk("message_addr", message_addr, MSG_BASE);
    chk("output_addr", output_addr, OUT_BASE);
    reset = 1'b0;
    chk("ld_ready_pre", ld_ready, 0);
    tick;
    chk("ld_ready_rise", ld_ready, 1);
    // run 1: counting message, plain dump
    for (int i = 0; i < 20; i++) w[i] = 32'(i + 1);
    load_msg;
    chk("read_word5", mem_read_data, 32'h6);
    digest;
    fire_done;
    dump(8, -1);
    // run 2: "abc" padded block, done stale-high into BUSY, stall at word 3
    for (int i = 0; i < 20; i++) w[i] = 32'h0;
    w[0] = 32'h61626380;
    w[15] = 32'h18;
    done = 1'b1;
    load_msg;
    digest;
    chk("stale_done_ignored", res_valid, 0);
    done = 1'b0;
    repeat (50) tick;
    fire_done;
    dump(8, 3);
    // run 3: engine write ignored in LOAD, protected and out-of-range writes
    mem_we = 1'b1;
    mem_addr = 16'd40;
    mem_write_data = ~ref_mem[40];
    tick;
    mem_we = 1'b0;
    chk("load_we_err", err_addr, 0);
    for (int i = 0; i < 20; i++) w[i] = $urandom;
    load_msg;
    eng_write(2, $urandom);
    eng_write(16'h40, 32'hDEADBEEF);
    digest;
    fire_done;
    dump(8, $urandom_range(7));
    rd_chk(0);
    rd_chk(2);
    rd_chk(40);
    rd_chk(16'h40);
    // run 4: watchdog abort after TIMEOUT busy cycles
    for (int i = 0; i < 20; i++) w[i] = $urandom;
    load_msg;
    repeat (TIMEOUT - 1) tick;
    chk("wd_before_timeout", err_timeout, 0);
    chk("wd_before_ld_ready", ld_ready, 0);
    tick;
    chk("wd_timeout", err_timeout, 1);
    chk("wd_ld_ready", ld_ready, 1);
    chk("wd_no_dump", res_valid, 0);
    // run 5: reset in the middle of a dump
    for (int i = 0; i < 20; i++) w[i] = $urandom;
    load_msg;
    digest;
    fire_done;
    dump(2, -1);
    reset = 1'b1;
    #1;
    chk("mid_dump_rst_valid", res_valid, 0);
    chk("mid_dump_rst_data", res_data, 0);
    chk("mid_dump_rst_ld_ready", ld_ready, 0);
    chk("mid_dump_rst_rdata", mem_read_data, 0);
    tick;
    reset = 1'b0;
    tick;
    chk("post_rst_ld_ready", ld_ready, 1);
    for (int a = 0; a < DEPTH; a++) if (ref_ok[a]) rd_chk(a);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/sha_mem_responder.md
SHA_MEM_RESPONDER -- requirements
Module: sha_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 64, meaning number of 32-bit words in the shared memory.
REQ-002 SHALL have parameter MSG_BASE, default 0, meaning word address of the 20-word message region.
REQ-003 SHALL have parameter OUT_BASE, default 32, meaning word address of the 16-word digest region.
REQ-004 SHALL have parameter TIMEOUT, default 1024, meaning the maximum number of BUSY cycles before abort.
REQ-005 Ports SHALL be (clock and reset first; one clock; reset is asynchronous and active-high):
- clk  in  1  sole clock
- reset  in  1  asynchronous, active-high reset
- mem_we  in  1  engine write strobe
- mem_addr  in  16  engine word address
- mem_write_data  in  32  engine write data
- mem_read_data  out  32  registered read data to engine
- start  out  1  one-cycle engine start pulse
- done  in  1  engine done level
- message_addr  out  16  constant MSG_BASE
- output_addr  out  16  constant OUT_BASE
- ld_valid  in  1  host load word valid
- ld_ready  out  1  host load word accepted
- ld_data  in  32  host load word
- res_valid  out  1  digest word valid
- res_ready  in  1  host digest accept
- res_data  out  32  digest word
- res_last  out  1  marks digest word 7
- err_addr  out  1  sticky engine address fault
- err_timeout  out  1  sticky watchdog abort

Function
REQ-006 The FSM SHALL have four states, LOAD, START, BUSY and DUMP, and SHALL enter LOAD on reset.
REQ-007 In LOAD, ld_ready SHALL be 1; each ld_valid&ld_ready handshake SHALL write ld_data to mem[MSG_BASE+n], n=0..19.
REQ-008 After the 20th handshake, the FSM SHALL go to START, and ld_ready SHALL be 0 from the next cycle.
REQ-009 START SHALL last one cycle with start=1, SHALL clear err_addr and err_timeout, and SHALL then go to BUSY.
REQ-010 In BUSY, the block SHALL detect the rising edge of done only; a done level that is still high from a prior run in the first BUSY cycle SHALL be ignored.
REQ-011 On the done rising edge, the FSM SHALL go to DUMP.
REQ-012 The watchdog SHALL count BUSY cycles; on reaching TIMEOUT without a done edge, it SHALL set err_timeout and return to LOAD without a dump.
REQ-013 Every cycle, in all states, mem_read_data SHALL be loaded with mem[mem_addr] (one-cycle read latency), or with 0 when mem_addr>=DEPTH.
REQ-014 An engine write SHALL occur only when mem_we=1 in BUSY; mem_we outside BUSY SHALL be ignored.
REQ-015 An engine write with mem_addr>=DEPTH SHALL be dropped and SHALL set err_addr.
REQ-016 When a read and a write target the same address in one cycle, mem_read_data SHALL return the old contents (read-before-write).
REQ-017 In DUMP, the block SHALL present mem[OUT_BASE+i], i=0..7, on res_data with res_valid=1, and res_last=1 when i=7.
REQ-018 In DUMP, res_data and res_last SHALL hold stable while res_ready=0.
REQ-019 After the i=7 handshake, the FSM SHALL return to LOAD, and res_valid SHALL be 0 the next cycle.
REQ-020 Engine writes to OUT_BASE+8..15 SHALL be stored but SHALL NOT be dumped.
REQ-021 Load word index, dump index and watchdog count SHALL reset to 0 on each entry to their state.

Reset
REQ-022 Asserting reset at any time, including mid-LOAD, mid-BUSY or mid-DUMP, SHALL immediately return the FSM to LOAD and clear all counters.
REQ-023 Under reset, outputs SHALL take these values: start=0, ld_ready=0, res_valid=0, res_last=0, res_data=0, mem_read_data=0, err_addr=0, err_timeout=0.
REQ-024 message_addr and output_addr SHALL be constants, unaffected by reset.
REQ-025 Memory contents SHALL NOT be cleared by reset.
REQ-026 ld_ready SHALL rise in the first cycle after reset deasserts.

Configuration
REQ-027 With macro SHA_MEM_WPROT_EN defined, engine writes to MSG_BASE..MSG_BASE+19 SHALL be dropped and SHALL set err_addr.
REQ-028 Without SHA_MEM_WPROT_EN, engine writes to MSG_BASE..MSG_BASE+19 SHALL be stored like any other in-range write.

Verification
REQ-029 Bench SHALL load 20 words 0x00000001..0x00000014, then drive mem_addr=0x0005 -> mem_read_data=0x00000006 one cycle later.
REQ-030 Bench SHALL run a full message "abc"-padded 20-word block with an engine model -> start pulses exactly once; 8 digest words dump; res_last only on the 8th.
REQ-031 Bench SHALL hold done=1 entering BUSY, then drop it and raise it 50 cycles later -> DUMP entered only after the rise.
REQ-032 Bench SHALL hold res_ready=0 for 5 cycles at i=3 -> res_data holds mem[35], no index advance.
REQ-033 Bench SHALL issue an engine write to mem_addr=0x0040 with data 0xDEADBEEF -> err_addr=1, no memory change; also a write to 0x0002 -> dropped with SHA_MEM_WPROT_EN, stored without it.
REQ-034 Bench SHALL omit done for 1024 BUSY cycles -> err_timeout=1, ld_ready=1 next cycle; also assert reset mid-DUMP -> res_valid=0 immediately and memory preserved.
